// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//
// AXI4 slave that backs the flattened 64-bit io_axi_mem_* port with an
// on-chip word array. One read burst and one write burst may be in flight at
// the same time, each on its own channel. FIXED and INCR bursts with byte
// strobes are supported. WRAP, size > 3 and any atomic (atop != 0) give
// SLVERR.
//
// Optional feature macro: AXI_MEM_RESPONDER_DECERR_EN
//   defined     : beats outside [BaseAddr, BaseAddr + 8*MemWords) answer DECERR
//                 and never touch the array
//   not defined : the word index wraps modulo MemWords, so every address
//                 aliases into the array
//
// Parameters
//   MemWords : array depth in 64-bit words (power of two, >= 2)
//   BaseAddr : byte address of word 0
//
// Ports
//   clk_i, rst_i         : clock and asynchronous active-high reset
//   io_axi_mem_aw*       : write address channel (lock/cache/prot/region/user/qos ignored)
//   io_axi_mem_w*        : write data channel (wuser ignored)
//   io_axi_mem_b*        : write response channel (buser always 0)
//   io_axi_mem_ar*       : read address channel (lock/cache/prot/region/user/qos ignored)
//   io_axi_mem_r*        : read data channel (ruser always 0)
module axi_mem_responder #(
  parameter int unsigned MemWords = 1024,
  parameter logic [63:0] BaseAddr = 64'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  io_axi_mem_awid,
  input  logic [63:0] io_axi_mem_awaddr,
  input  logic [7:0]  io_axi_mem_awlen,
  input  logic [2:0]  io_axi_mem_awsize,
  input  logic [1:0]  io_axi_mem_awburst,
  input  logic        io_axi_mem_awlock,
  input  logic [3:0]  io_axi_mem_awcache,
  input  logic [2:0]  io_axi_mem_awprot,
  input  logic [3:0]  io_axi_mem_awregion,
  input  logic [3:0]  io_axi_mem_awuser,
  input  logic [3:0]  io_axi_mem_awqos,
  input  logic [5:0]  io_axi_mem_awatop,
  input  logic        io_axi_mem_awvalid,
  output logic        io_axi_mem_awready,
  input  logic [63:0] io_axi_mem_wdata,
  input  logic [7:0]  io_axi_mem_wstrb,
  input  logic        io_axi_mem_wlast,
  input  logic [3:0]  io_axi_mem_wuser,
  input  logic        io_axi_mem_wvalid,
  output logic        io_axi_mem_wready,
  output logic [3:0]  io_axi_mem_bid,
  output logic [1:0]  io_axi_mem_bresp,
  output logic [3:0]  io_axi_mem_buser,
  output logic        io_axi_mem_bvalid,
  input  logic        io_axi_mem_bready,
  input  logic [3:0]  io_axi_mem_arid,
  input  logic [63:0] io_axi_mem_araddr,
  input  logic [7:0]  io_axi_mem_arlen,
  input  logic [2:0]  io_axi_mem_arsize,
  input  logic [1:0]  io_axi_mem_arburst,
  input  logic        io_axi_mem_arlock,
  input  logic [3:0]  io_axi_mem_arcache,
  input  logic [2:0]  io_axi_mem_arprot,
  input  logic [3:0]  io_axi_mem_arregion,
  input  logic [3:0]  io_axi_mem_aruser,
  input  logic [3:0]  io_axi_mem_arqos,
  input  logic        io_axi_mem_arvalid,
  output logic        io_axi_mem_arready,
  output logic [3:0]  io_axi_mem_rid,
  output logic [63:0] io_axi_mem_rdata,
  output logic [1:0]  io_axi_mem_rresp,
  output logic        io_axi_mem_rlast,
  output logic [3:0]  io_axi_mem_ruser,
  output logic        io_axi_mem_rvalid,
  input  logic        io_axi_mem_rready
);

  localparam int unsigned IW = $clog2(MemWords);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlv    = 2'b10;
  localparam logic [1:0] RespDec    = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

`ifdef AXI_MEM_RESPONDER_DECERR_EN
  localparam bit DecErrEn = 1'b1;
`else
  localparam bit DecErrEn = 1'b0;
`endif

  // Low index bits of the word offset; this is the aliasing behaviour when
  // range checking is off.
  function automatic logic [IW-1:0] f_idx(input logic [63:0] a);
    return IW'((a - BaseAddr) >> 3);
  endfunction

  function automatic logic f_oor(input logic [63:0] a);
    return DecErrEn && ((a < BaseAddr) || (((a - BaseAddr) >> 3) >= 64'(MemWords)));
  endfunction

  function automatic logic [63:0] f_step(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BurstFixed) ? 64'd0 : (64'd1 << size);
  endfunction

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // ---------------- read channel state ----------------
  r_state_t    r_rstate;
  logic        r_arready;
  logic        r_rvalid;
  logic        r_rlast;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rid;
  logic [63:0] r_raddr;
  logic [7:0]  r_rlen;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [7:0]  r_rcnt;
  logic        r_rberr;
  logic        r_rzero;    // current beat returns zero data (error beat)

  logic        w_ar_hs;
  logic        w_r_hs;
  logic [63:0] w_raddr_next;
  logic [63:0] w_rd_addr;
  logic        w_rd_en;
  logic [IW-1:0] w_rd_idx;
  logic        w_ar_berr;
  logic        w_rd_berr;
  logic        w_rd_oor;
  logic [1:0]  w_rd_resp;
  logic [63:0] w_rd_word;

  assign w_ar_hs      = io_axi_mem_arvalid && r_arready;
  assign w_r_hs       = r_rvalid && io_axi_mem_rready;
  assign w_raddr_next = r_raddr + f_step(r_rburst, r_rsize);
  // The array is read one cycle ahead: on the AR handshake for beat 0 and on
  // each accepted non-final beat for the next one. While stalled nothing is
  // read, so the presented word holds even if the same word is written.
  assign w_rd_addr    = w_ar_hs ? io_axi_mem_araddr : w_raddr_next;
  assign w_rd_en      = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_rd_idx     = f_idx(w_rd_addr);
  assign w_ar_berr    = (io_axi_mem_arsize > 3'd3) || (io_axi_mem_arburst == BurstWrap);
  assign w_rd_berr    = w_ar_hs ? w_ar_berr : r_rberr;
  assign w_rd_oor     = f_oor(w_rd_addr);
  assign w_rd_resp    = w_rd_berr ? RespSlv : (w_rd_oor ? RespDec : RespOkay);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RespOkay;
      r_rid     <= 4'd0;
      r_raddr   <= 64'd0;
      r_rlen    <= 8'd0;
      r_rsize   <= 3'd0;
      r_rburst  <= 2'd0;
      r_rcnt    <= 8'd0;
      r_rberr   <= 1'b0;
      r_rzero   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= io_axi_mem_arid;
            r_raddr   <= io_axi_mem_araddr;
            r_rlen    <= io_axi_mem_arlen;
            r_rsize   <= io_axi_mem_arsize;
            r_rburst  <= io_axi_mem_arburst;
            r_rcnt    <= 8'd0;
            r_rberr   <= w_ar_berr;
            r_rzero   <= w_ar_berr || w_rd_oor;
            r_rresp   <= w_rd_resp;
            r_rlast   <= (io_axi_mem_arlen == 8'd0);
            r_rvalid  <= 1'b1;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_rresp   <= RespOkay;
              r_rzero   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_raddr_next;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
              r_rzero <= w_rd_berr || w_rd_oor;
              r_rresp <= w_rd_resp;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel state ----------------
  w_state_t    r_wstate;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_wid;
  logic [63:0] r_waddr;
  logic [7:0]  r_wlen;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic [7:0]  r_wcnt;
  logic        r_wberr;    // burst-level error: no beat of this burst is written
  logic        r_wdec;     // an out-of-range beat was dropped
  logic        r_wpast;    // beat awlen accepted without wlast; discard until wlast

  logic        w_aw_hs;
  logic        w_w_hs;
  logic [IW-1:0] w_wr_idx;
  logic        w_wr_oor;
  logic        w_aw_berr;
  logic        w_we;
  logic        w_b_dec;
  logic        w_b_slv;
  logic [1:0]  w_bresp;

  assign w_aw_hs   = io_axi_mem_awvalid && r_awready;
  assign w_w_hs    = io_axi_mem_wvalid && r_wready;
  assign w_wr_idx  = f_idx(r_waddr);
  assign w_wr_oor  = f_oor(r_waddr);
  assign w_aw_berr = (io_axi_mem_awsize > 3'd3) || (io_axi_mem_awburst == BurstWrap) ||
                     (io_axi_mem_awatop != 6'd0);
  assign w_we      = w_w_hs && !r_wpast && !r_wberr && !w_wr_oor;
  assign w_b_dec   = r_wdec || (!r_wpast && w_wr_oor);
  // wlast on a beat other than awlen (early) or after it (late) is a mismatch.
  assign w_b_slv   = r_wberr || r_wpast || (r_wcnt != r_wlen);
  assign w_bresp   = w_b_dec ? RespDec : (w_b_slv ? RespSlv : RespOkay);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RespOkay;
      r_wid     <= 4'd0;
      r_waddr   <= 64'd0;
      r_wlen    <= 8'd0;
      r_wsize   <= 3'd0;
      r_wburst  <= 2'd0;
      r_wcnt    <= 8'd0;
      r_wberr   <= 1'b0;
      r_wdec    <= 1'b0;
      r_wpast   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wid     <= io_axi_mem_awid;
            r_waddr   <= io_axi_mem_awaddr;
            r_wlen    <= io_axi_mem_awlen;
            r_wsize   <= io_axi_mem_awsize;
            r_wburst  <= io_axi_mem_awburst;
            r_wcnt    <= 8'd0;
            r_wberr   <= w_aw_berr;
            r_wdec    <= 1'b0;
            r_wpast   <= 1'b0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (!r_wpast) begin
              r_waddr <= r_waddr + f_step(r_wburst, r_wsize);
              r_wcnt  <= r_wcnt + 8'd1;
              if (w_wr_oor) r_wdec <= 1'b1;
              if (!io_axi_mem_wlast && (r_wcnt == r_wlen)) r_wpast <= 1'b1;
            end
            if (io_axi_mem_wlast) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_bresp;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (io_axi_mem_bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RespOkay;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- storage: one byte-wide array per strobe lane ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] r_lane [MemWords];
      logic [7:0] r_rd_byte;
      always_ff @(posedge clk_i) begin
        if (w_we && io_axi_mem_wstrb[gi]) r_lane[w_wr_idx] <= io_axi_mem_wdata[gi*8 +: 8];
        if (w_rd_en) r_rd_byte <= r_lane[w_rd_idx];
      end
      assign w_rd_word[gi*8 +: 8] = r_rd_byte;
    end
  endgenerate

  // ---------------- outputs ----------------
  assign io_axi_mem_awready = r_awready;
  assign io_axi_mem_wready  = r_wready;
  assign io_axi_mem_bid     = r_wid;
  assign io_axi_mem_bresp   = r_bresp;
  assign io_axi_mem_buser   = 4'd0;
  assign io_axi_mem_bvalid  = r_bvalid;
  assign io_axi_mem_arready = r_arready;
  assign io_axi_mem_rid     = r_rid;
  assign io_axi_mem_rdata   = (r_rvalid && !r_rzero) ? w_rd_word : 64'd0;
  assign io_axi_mem_rresp   = r_rresp;
  assign io_axi_mem_rlast   = r_rlast;
  assign io_axi_mem_ruser   = 4'd0;
  assign io_axi_mem_rvalid  = r_rvalid;

  logic w_unused;
  assign w_unused = ^{io_axi_mem_awlock, io_axi_mem_awcache, io_axi_mem_awprot,
                      io_axi_mem_awregion, io_axi_mem_awuser, io_axi_mem_awqos,
                      io_axi_mem_wuser, io_axi_mem_arlock, io_axi_mem_arcache,
                      io_axi_mem_arprot, io_axi_mem_arregion, io_axi_mem_aruser,
                      io_axi_mem_arqos};

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
  localparam int MW = 1024;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  awid = 0;   logic [63:0] awaddr = 0; logic [7:0] awlen = 0;
  logic [2:0]  awsize = 0; logic [1:0]  awburst = 0; logic [5:0] awatop = 0;
  logic        awvalid = 0; logic awready;
  logic [63:0] wdata = 0;  logic [7:0] wstrb = 0; logic wlast = 0; logic wvalid = 0; logic wready;
  logic [3:0]  bid; logic [1:0] bresp; logic [3:0] buser; logic bvalid; logic bready = 0;
  logic [3:0]  arid = 0;   logic [63:0] araddr = 0; logic [7:0] arlen = 0;
  logic [2:0]  arsize = 0; logic [1:0]  arburst = 0; logic arvalid = 0; logic arready;
  logic [3:0]  rid; logic [63:0] rdata; logic [1:0] rresp; logic rlast; logic [3:0] ruser;
  logic        rvalid; logic rready = 0;

  axi_mem_responder #(.MemWords(MW), .BaseAddr(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .io_axi_mem_awid(awid), .io_axi_mem_awaddr(awaddr), .io_axi_mem_awlen(awlen),
    .io_axi_mem_awsize(awsize), .io_axi_mem_awburst(awburst), .io_axi_mem_awlock(1'b0),
    .io_axi_mem_awcache(4'd0), .io_axi_mem_awprot(3'd0), .io_axi_mem_awregion(4'd0),
    .io_axi_mem_awuser(4'd0), .io_axi_mem_awqos(4'd0), .io_axi_mem_awatop(awatop),
    .io_axi_mem_awvalid(awvalid), .io_axi_mem_awready(awready),
    .io_axi_mem_wdata(wdata), .io_axi_mem_wstrb(wstrb), .io_axi_mem_wlast(wlast),
    .io_axi_mem_wuser(4'd0), .io_axi_mem_wvalid(wvalid), .io_axi_mem_wready(wready),
    .io_axi_mem_bid(bid), .io_axi_mem_bresp(bresp), .io_axi_mem_buser(buser),
    .io_axi_mem_bvalid(bvalid), .io_axi_mem_bready(bready),
    .io_axi_mem_arid(arid), .io_axi_mem_araddr(araddr), .io_axi_mem_arlen(arlen),
    .io_axi_mem_arsize(arsize), .io_axi_mem_arburst(arburst), .io_axi_mem_arlock(1'b0),
    .io_axi_mem_arcache(4'd0), .io_axi_mem_arprot(3'd0), .io_axi_mem_arregion(4'd0),
    .io_axi_mem_aruser(4'd0), .io_axi_mem_arqos(4'd0),
    .io_axi_mem_arvalid(arvalid), .io_axi_mem_arready(arready),
    .io_axi_mem_rid(rid), .io_axi_mem_rdata(rdata), .io_axi_mem_rresp(rresp),
    .io_axi_mem_rlast(rlast), .io_axi_mem_ruser(ruser), .io_axi_mem_rvalid(rvalid),
    .io_axi_mem_rready(rready)
  );

  wire [89:0] all_outs = {awready, wready, bid, bresp, buser, bvalid, arready,
                          rid, rdata, rresp, rlast, ruser, rvalid};

  int errors = 0;
  int checks = 0;

  // Reference memory: what each word must hold after the writes issued so far.
  logic [63:0] model [MW];
  logic [63:0] wbuf [32];
  logic [7:0]  sbuf [32];
  logic [63:0] rdat [32];
  logic [1:0]  rrsp [32];
  logic        rlst [32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_addr(input logic [63:0] a, input int b,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + (64'(b) << size);
  endfunction

  function automatic int widx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return int'((off >> 3) % 64'(MW));
  endfunction

  // Drives one AW + nbeats W beats (wlast on the final one) and collects B.
  // Applies the burst to the reference memory and returns the expected bresp.
  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop,
                          input int nbeats, output logic [3:0] o_bid, output logic [1:0] o_resp,
                          output logic [1:0] exp_resp, output int blat, output bit to);
    int k;
    bit err;
    int i;
    to = 0; o_bid = 0; o_resp = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awatop = atop;
    awvalid = 1;
    k = 0;
    while (!awready && k < 50) begin step(); k++; end
    if (!awready) to = 1;
    step();
    awvalid = 0;
    for (int b = 0; b < nbeats; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == nbeats - 1); wvalid = 1;
      k = 0;
      while (!wready && k < 50) begin step(); k++; end
      if (!wready) to = 1;
      step();
    end
    wvalid = 0; wlast = 0;
    bready = 1;
    blat = 0;
    while (!bvalid && blat < 50) begin step(); blat++; end
    if (!bvalid) to = 1;
    o_bid = bid; o_resp = bresp;
    step();
    bready = 0;
    err = (size > 3) || (burst == 2'b10) || (atop != 0);
    if (!err) begin
      for (int b = 0; b < nbeats && b <= int'(len); b++) begin
        i = widx(beat_addr(addr, b, size, burst));
        for (int j = 0; j < 8; j++)
          if (sbuf[b][j]) model[i][j*8 +: 8] = wbuf[b][j*8 +: 8];
      end
    end
    exp_resp = (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
  endtask

  // Issues one AR and collects len+1 beats, driving rready from pattern pat
  // (bit c % plen in sample c). Reports first-beat latency, number of samples
  // where a stalled beat changed, and arready right after the last beat.
  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [31:0] pat, input int plen,
                         output int lat, output int unstable, output logic ar_after,
                         output logic [3:0] o_rid, output bit to);
    int k, beats, c;
    bit seen, stalled;
    logic rr;
    logic [63:0] pd;
    logic [1:0] pr;
    logic pl;
    to = 0; o_rid = 0; pd = 0; pr = 0; pl = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1;
    k = 0;
    while (!arready && k < 50) begin step(); k++; end
    if (!arready) to = 1;
    step();
    arvalid = 0;
    beats = 0; c = 0; lat = 0; seen = 0; stalled = 0; unstable = 0;
    while (beats < int'(len) + 1 && c < 400) begin
      rr = pat[c % plen];
      rready = rr;
      if (rvalid) begin
        if (!seen) begin seen = 1; o_rid = rid; end
        if (stalled && (rdata !== pd || rresp !== pr || rlast !== pl)) unstable++;
        if (rr) begin
          rdat[beats] = rdata; rrsp[beats] = rresp; rlst[beats] = rlast;
          beats++; stalled = 0;
        end else begin
          stalled = 1; pd = rdata; pr = rresp; pl = rlast;
        end
      end else if (!seen) begin
        lat++;
      end
      step();
      c++;
    end
    rready = 0;
    if (beats < int'(len) + 1) to = 1;
    ar_after = arready;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if (all_outs !== 90'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_outs); end
    rst = 0;
    step();
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b want 1", awready); end
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", arready); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    logic [3:0] b_id, r_id; logic [1:0] b_rsp, e_rsp; int blat, lat, uns; bit to; logic aa;
    wbuf[0] = 64'hDEAD_BEEF_0123_4567; sbuf[0] = 8'hFF;
    do_write(4'h5, BASE + 64'h10, 8'd0, 3'd3, 2'b01, 6'd0, 1, b_id, b_rsp, e_rsp, blat, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_wr_timeout: got timeout want done"); end
    checks++;
    if (b_rsp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %h want 0", b_rsp); end
    checks++;
    if (b_id !== 4'h5) begin errors++; $display("FAIL single_bid: got %h want 5", b_id); end
    checks++;
    if (blat !== 0) begin errors++; $display("FAIL single_blat: got %0d want 0", blat); end
    do_read(4'h9, BASE + 64'h10, 8'd0, 3'd3, 2'b01, 32'h1, 1, lat, uns, aa, r_id, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_rd_timeout: got timeout want done"); end
    checks++;
    if (rdat[0] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL single_rdata: got %h want deadbeef01234567", rdat[0]); end
    checks++;
    if (rlst[0] !== 1'b1 || rrsp[0] !== 2'b00) begin errors++; $display("FAIL single_rlast_rresp: got %b/%h want 1/0", rlst[0], rrsp[0]); end
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL single_rlat: got %0d want 0", lat); end
    checks++;
    if (r_id !== 4'h9) begin errors++; $display("FAIL single_rid: got %h want 9", r_id); end
    $display("test_single: bid=%h bresp=%h rdata=%h", b_id, b_rsp, rdat[0]);
  endtask

  task automatic test_incr_read();
    logic [3:0] b_id, r_id; logic [1:0] b_rsp, e_rsp; int blat, lat, uns; bit to; logic aa;
    for (int b = 0; b < 4; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
    do_write(4'h1, BASE, 8'd3, 3'd3, 2'b01, 6'd0, 4, b_id, b_rsp, e_rsp, blat, to);
    checks++;
    if (to || b_rsp !== 2'b00) begin errors++; $display("FAIL incr_preload: got to=%0d bresp=%h want 0/0", to, b_rsp); end
    do_read(4'h2, BASE, 8'd3, 3'd3, 2'b01, 32'b101101, 6, lat, uns, aa, r_id, to);
    checks++;
    if (to) begin errors++; $display("FAIL incr_timeout: got timeout want done"); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rdat[b] !== model[b]) begin errors++; $display("FAIL incr_data[%0d]: got %h want %h", b, rdat[b], model[b]); end
      checks++;
      if (rlst[b] !== (b == 3)) begin errors++; $display("FAIL incr_rlast[%0d]: got %b want %b", b, rlst[b], (b == 3)); end
    end
    checks++;
    if (uns !== 0) begin errors++; $display("FAIL incr_stable: got %0d changes want 0", uns); end
    checks++;
    if (aa !== 1'b1) begin errors++; $display("FAIL incr_arready_after: got %b want 1", aa); end
    $display("test_incr_read: 4 beats unstable=%0d arready_after=%b", uns, aa);
  endtask

  task automatic test_strobe();
    logic [3:0] b_id, r_id; logic [1:0] b_rsp, e_rsp; int blat, lat, uns; bit to; logic aa;
    wbuf[0] = 64'h1111_1111_1111_1111; sbuf[0] = 8'hFF;
    do_write(4'h3, BASE + 64'h10, 8'd0, 3'd3, 2'b01, 6'd0, 1, b_id, b_rsp, e_rsp, blat, to);
    wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA; sbuf[0] = 8'h0F;
    do_write(4'h3, BASE + 64'h10, 8'd0, 3'd3, 2'b01, 6'd0, 1, b_id, b_rsp, e_rsp, blat, to);
    checks++;
    if (to || b_rsp !== 2'b00) begin errors++; $display("FAIL strobe_bresp: got to=%0d bresp=%h want 0/0", to, b_rsp); end
    do_read(4'h3, BASE + 64'h10, 8'd0, 3'd3, 2'b01, 32'h1, 1, lat, uns, aa, r_id, to);
    checks++;
    if (rdat[0] !== 64'h1111_1111_AAAA_AAAA) begin errors++; $display("FAIL strobe_merge: got %h want 11111111aaaaaaaa", rdat[0]); end
    $display("test_strobe: rdata=%h", rdat[0]);
  endtask

  task automatic test_wrap_err();
    logic [3:0] b_id, r_id; logic [1:0] b_rsp, e_rsp; int blat, lat, uns; bit to; logic aa;
    wbuf[0] = 64'h5555_0000_1234_5678; sbuf[0] = 8'hFF;
    do_write(4'h4, BASE + 64'h28, 8'd0, 3'd3, 2'b01, 6'd0, 1, b_id, b_rsp, e_rsp, blat, to);
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(4'h6, BASE + 64'h28, 8'd0, 3'd3, 2'b10, 6'd0, 1, b_id, b_rsp, e_rsp, blat, to);
    checks++;
    if (to || b_rsp !== 2'b10) begin errors++; $display("FAIL wrap_bresp: got to=%0d bresp=%h want 0/2", to, b_rsp); end
    wbuf[0] = 64'hEEEE_EEEE_EEEE_EEEE;
    do_write(4'h7, BASE + 64'h28, 8'd0, 3'd3, 2'b01, 6'd1, 1, b_id, b_rsp, e_rsp, blat, to);
    checks++;
    if (b_rsp !== 2'b10) begin errors++; $display("FAIL atop_bresp: got %h want 2", b_rsp); end
    do_read(4'h4, BASE + 64'h28, 8'd0, 3'd3, 2'b01, 32'h1, 1, lat, uns, aa, r_id, to);
    checks++;
    if (rdat[0] !== 64'h5555_0000_1234_5678) begin errors++; $display("FAIL wrap_unchanged: got %h want 5555000012345678", rdat[0]); end
    do_read(4'h4, BASE + 64'h28, 8'd0, 3'd3, 2'b10, 32'h1, 1, lat, uns, aa, r_id, to);
    checks++;
    if (rdat[0] !== 64'd0 || rrsp[0] !== 2'b10) begin errors++; $display("FAIL wrap_read: got %h/%h want 0/2", rdat[0], rrsp[0]); end
    $display("test_wrap_err: bresp=%h", b_rsp);
  endtask

  task automatic test_wlast_mismatch();
    logic [3:0] b_id, r_id; logic [1:0] b_rsp, e_rsp; int blat, lat, uns; bit to; logic aa;
    for (int b = 0; b < 8; b++) begin wbuf[b] = 64'h0101_0101_0101_0101 * (b + 1); sbuf[b] = 8'hFF; end
    do_write(4'h1, BASE, 8'd7, 3'd3, 2'b01, 6'd0, 8, b_id, b_rsp, e_rsp, blat, to);
    wbuf[0] = 64'hC0C0_0000_0000_0000; wbuf[1] = 64'hC1C1_0000_0000_0001;
    do_write(4'h2, BASE, 8'd3, 3'd3, 2'b01, 6'd0, 2, b_id, b_rsp, e_rsp, blat, to);
    checks++;
    if (to || b_rsp !== 2'b10) begin errors++; $display("FAIL early_bresp: got to=%0d bresp=%h want 0/2", to, b_rsp); end
    wbuf[0] = 64'h6666_0000_0000_0006; wbuf[1] = 64'h7777_7777_7777_7777; wbuf[2] = 64'h8888_8888_8888_8888;
    do_write(4'h3, BASE + 64'h30, 8'd0, 3'd3, 2'b01, 6'd0, 3, b_id, b_rsp, e_rsp, blat, to);
    checks++;
    if (to || b_rsp !== 2'b10) begin errors++; $display("FAIL late_bresp: got to=%0d bresp=%h want 0/2", to, b_rsp); end
    do_read(4'h5, BASE, 8'd7, 3'd3, 2'b01, 32'h1, 1, lat, uns, aa, r_id, to);
    checks++;
    if (rdat[0] !== 64'hC0C0_0000_0000_0000 || rdat[1] !== 64'hC1C1_0000_0000_0001) begin
      errors++; $display("FAIL early_written: got %h %h want c0c0000000000000 c1c1000000000001", rdat[0], rdat[1]);
    end
    for (int b = 2; b < 8; b++) begin
      checks++;
      if (rdat[b] !== model[b]) begin errors++; $display("FAIL mismatch_word[%0d]: got %h want %h", b, rdat[b], model[b]); end
    end
    $display("test_wlast_mismatch: early/late bresp checked");
  endtask

  task automatic test_oor();
    logic [3:0] r_id; int lat, uns; bit to; logic aa;
    do_read(4'hA, BASE + 64'(8 * MW), 8'd0, 3'd3, 2'b01, 32'h1, 1, lat, uns, aa, r_id, to);
    checks++;
`ifdef AXI_MEM_RESPONDER_DECERR_EN
    if (to || rdat[0] !== 64'd0 || rrsp[0] !== 2'b11) begin
      errors++; $display("FAIL oor_read: got %h/%h want 0/3", rdat[0], rrsp[0]);
    end
`else
    if (to || rdat[0] !== model[0] || rrsp[0] !== 2'b00) begin
      errors++; $display("FAIL oor_read: got %h/%h want %h/0", rdat[0], rrsp[0], model[0]);
    end
`endif
    $display("test_oor: rdata=%h rresp=%h", rdat[0], rrsp[0]);
  endtask

  task automatic test_mid_reset();
    logic [3:0] b_id, r_id; logic [1:0] b_rsp, e_rsp; int blat, lat, uns, bi, k; bit to; logic aa;
    for (int b = 0; b < 8; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
    do_write(4'h2, BASE + 64'h40, 8'd7, 3'd3, 2'b01, 6'd0, 8, b_id, b_rsp, e_rsp, blat, to);
    araddr = BASE + 64'h40; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arid = 4'hB;
    arvalid = 1;
    k = 0;
    while (!arready && k < 50) begin step(); k++; end
    step();
    arvalid = 0;
    rready = 1;
    bi = 0; k = 0;
    while (k < 30 && !(rvalid && bi == 2)) begin
      if (rvalid) bi++;
      step();
      k++;
    end
    checks++;
    if (!(rvalid && bi == 2)) begin errors++; $display("FAIL midrst_reach_beat2: got beat %0d want 2", bi); end
    rst = 1;
    #1;
    checks++;
    if (all_outs !== 90'd0) begin errors++; $display("FAIL midrst_outs: got %h want 0", all_outs); end
    rready = 0;
    step(); step();
    checks++;
    if (all_outs !== 90'd0) begin errors++; $display("FAIL midrst_outs_held: got %h want 0", all_outs); end
    rst = 0;
    step();
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL midrst_release: got arready=%b rvalid=%b want 1/0", arready, rvalid); end
    do_read(4'hC, BASE + 64'h48, 8'd1, 3'd3, 2'b01, 32'h1, 1, lat, uns, aa, r_id, to);
    checks++;
    if (to || rdat[0] !== model[9] || rdat[1] !== model[10] || rlst[1] !== 1'b1) begin
      errors++; $display("FAIL midrst_newread: got %h %h want %h %h", rdat[0], rdat[1], model[9], model[10]);
    end
    $display("test_mid_reset: new read %h %h", rdat[0], rdat[1]);
  endtask

  task automatic test_random();
    logic [3:0] b_id, r_id, id; logic [1:0] b_rsp, e_rsp, bu; logic [2:0] sz; logic [7:0] ln;
    logic [63:0] a, ex; int blat, lat, uns, w; bit to; logic aa;
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 16; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
      do_write(4'(g), BASE + 64'(g * 128), 8'd15, 3'd3, 2'b01, 6'd0, 16, b_id, b_rsp, e_rsp, blat, to);
      checks++;
      if (to || b_rsp !== 2'b00) begin errors++; $display("FAIL rand_fill[%0d]: got to=%0d bresp=%h want 0/0", g, to, b_rsp); end
    end
    for (int it = 0; it < 12; it++) begin
      id = 4'($urandom); ln = 8'($urandom_range(0, 7)); sz = 3'($urandom_range(0, 3));
      bu = 2'($urandom_range(0, 1)); w = $urandom_range(0, 47);
      a = BASE + 64'(w * 8) + ((64'($urandom_range(0, 7)) >> sz) << sz);
      for (int b = 0; b <= int'(ln); b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'($urandom); end
      do_write(id, a, ln, sz, bu, 6'd0, int'(ln) + 1, b_id, b_rsp, e_rsp, blat, to);
      checks++;
      if (to || b_rsp !== e_rsp || b_id !== id) begin
        errors++; $display("FAIL rand_wr[%0d]: got bresp=%h bid=%h want %h/%h", it, b_rsp, b_id, e_rsp, id);
      end
      id = 4'($urandom); ln = 8'($urandom_range(0, 15)); sz = 3'($urandom_range(0, 3));
      bu = 2'($urandom_range(0, 1)); w = $urandom_range(0, 47);
      a = BASE + 64'(w * 8);
      do_read(id, a, ln, sz, bu, $urandom | 32'h1, 8, lat, uns, aa, r_id, to);
      checks++;
      if (to || r_id !== id || uns !== 0) begin
        errors++; $display("FAIL rand_rd[%0d]: got to=%0d rid=%h unstable=%0d want 0/%h/0", it, to, r_id, uns, id);
      end
      for (int b = 0; b <= int'(ln); b++) begin
        ex = model[widx(beat_addr(a, b, sz, bu))];
        checks++;
        if (rdat[b] !== ex || rrsp[b] !== 2'b00 || rlst[b] !== (b == int'(ln))) begin
          errors++; $display("FAIL rand_beat[%0d.%0d]: got %h/%h/%b want %h/0/%b", it, b, rdat[b], rrsp[b], rlst[b], ex, (b == int'(ln)));
        end
      end
      $display("test_random[%0d]: wr ok, rd len=%0d size=%0d burst=%0d", it, ln, sz, bu);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_read();
    test_strobe();
    test_wrap_err();
    test_wlast_mismatch();
    test_oor();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave that terminates the flattened 64-bit `io_axi_mem_*` memory port driven by the core wrapper. It backs the port with an on-chip word array for simulation and FPGA bring-up. It serves one read burst and one write burst concurrently, on independent channels, and supports FIXED and INCR bursts with byte strobes.

## Interface
- `MemWords`, default 1024: array depth in 64-bit words; must be a power of two.
- `BaseAddr`, default 64'h8000_0000: byte address of word 0.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `io_axi_mem_aw{id,addr,len,size,burst,lock,cache,prot,region,user,qos,atop,valid}` in 4/64/8/3/2/1/4/3/4/4/4/6/1: write address; lock/cache/prot/region/user/qos ignored.
- `io_axi_mem_awready` out 1.
- `io_axi_mem_w{data,strb,last,user,valid}` in 64/8/1/4/1; `io_axi_mem_wready` out 1.
- `io_axi_mem_b{id,resp,user,valid}` out 4/2/4/1; `io_axi_mem_bready` in 1.
- `io_axi_mem_ar{id,addr,len,size,burst,lock,cache,prot,region,user,qos,valid}` in 4/64/8/3/2/1/4/3/4/4/4/1; `io_axi_mem_arready` out 1.
- `io_axi_mem_r{id,data,resp,last,user,valid}` out 4/64/2/1/4/1; `io_axi_mem_rready` in 1.

## Operation
- Word index is `(addr - BaseAddr) >> 3`; beat address advances by `1 << size` for INCR and is constant for FIXED.
- Read FSM:
  - R_IDLE: `arready`=1. An AR handshake captures id, addr, len, size and burst, then goes to R_DATA.
  - R_DATA: `rvalid`=1, and `rdata` is the array word at the current beat index. Each `rvalid&&rready` advances the beat.
  - `rlast`=1 on beat `arlen`. The handshake on the last beat returns the FSM to R_IDLE.
- Write FSM:
  - W_IDLE: `awready`=1. An AW handshake goes to W_DATA.
  - W_DATA: `wready`=1. Each handshake writes the bytes where `wstrb` is 1.
  - A beat with `wlast`=1 moves the FSM to W_RESP.
  - W_RESP: `bvalid`=1 with `bid` = captured awid. `bready` returns the FSM to W_IDLE.
- Burst errors: SLVERR (2'b10) for `size`>3, burst=WRAP, or `atop`!=0.
  - Reads: every beat returns `rdata`=0.
  - Writes: no beat is written; the sticky write-error flag is set.
- `wlast` mismatch:
  - Early `wlast` ends the burst.
  - Beats after beat `awlen` are accepted and discarded until `wlast` arrives.
  - Either case gives `bresp`=SLVERR. Beats accepted before the mismatch stay written.
- `bresp` priority: DECERR, then SLVERR, then OKAY. `rresp` is set per beat.
- `buser` and `ruser` are always 0.
- Same-cycle read and write to one word: the read returns the old data.

## Timing
- While `rst_i`=1, every output is 0, including `awready` and `arready`. Both FSMs return to IDLE.
- Array contents are not reset. A reset in mid-burst abandons the burst, and beats already written are kept.
- `awready` and `arready` rise in the first cycle after `rst_i` deasserts.
- AR handshake at cycle N gives first `rvalid` at N+1. Reads then run at one beat per cycle while `rready`=1.
- Last W beat at cycle N gives `bvalid` at N+1.
- Only one burst is outstanding per direction. There is one idle cycle between back-to-back bursts on the same channel.
- `rvalid`, `rdata`, `rresp` and `rlast` hold stable while `rready`=0. `bvalid` and `bresp` hold stable while `bready`=0.
- An AW handshake in the same cycle as an AR handshake is legal; the channels are fully independent.

## Configuration
- `AXI_MEM_RESPONDER_DECERR_EN` defined:
  - A beat whose address is below `BaseAddr`, or whose word index is >= `MemWords`, is out of range.
  - An out-of-range read beat returns data 0 with `rresp`=DECERR (2'b11).
  - An out-of-range write beat is dropped, and the burst's `bresp`=DECERR.
- Not defined: the index is taken modulo `MemWords` (its low bits), so any address aliases into the array and no DECERR is ever produced.

## Test plan
- Single write then read: AW addr 0x8000_0010, len 0, size 3, `wdata`=0xDEAD_BEEF_0123_4567, `wstrb`=0xFF, then AR to the same address.
  - Required: `bresp`=OKAY, `bid` = `awid`; `rdata`=0xDEAD_BEEF_0123_4567 with `rlast`=1 at AR+1.
- INCR read burst: len 3 at 0x8000_0000 with `rready` toggled 1,0,1,1,0,1.
  - Required: 4 beats of words 0..3, in order, stable while stalled; `rlast` only on beat 3; `arready` returns the cycle after the last beat.
- Strobe merge: preload 0x1111_1111_1111_1111, then write 0xAAAA_AAAA_AAAA_AAAA with `wstrb`=0x0F.
  - Required: read-back 0x1111_1111_AAAA_AAAA.
- Error cases:
  - `awburst`=WRAP: `bresp`=SLVERR and memory unchanged.
  - Early `wlast` on beat 1 of len 3: `bresp`=SLVERR, and words 0..1 are written.
- Out of range: read at 0x8000_0000 + 8*`MemWords`.
  - With the macro: `rresp`=DECERR, `rdata`=0.
  - Without the macro: word 0 is returned with OKAY.
- Reset in mid-burst: assert `rst_i` on beat 2 of an 8-beat read.
  - Required: all outputs 0 during reset; `arready`=1 after release; a new read completes normally.
